pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 Parameter IMEM_BYTES, default 72, instruction memory size in bytes.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 imem_addr  output  32  byte address to instruction memory, equal to current PC.
REQ-006 imem_data  input  32  big-endian instruction word returned combinationally for imem_addr.
REQ-007 stall  input  1  hold PC and fetch register.
REQ-008 flush  input  1  squash the instruction being captured this cycle.
REQ-009 br_taken  input  1  redirect PC this cycle.
REQ-010 br_target  input  32  redirect byte address.
REQ-011 id_valid  output  1  fetch register holds a live instruction.
REQ-012 id_inst  output  32  captured instruction word.
REQ-013 id_pc  output  32  address of id_inst.
REQ-014 id_pc4  output  32  id_pc + 4.
REQ-015 fetch_fault  output  1  sticky misaligned or out-of-range fetch flag.
REQ-016 perf_fetch_cnt  output  32  count of instructions delivered with id_valid=1.

Function
REQ-017 States SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one clk, capture nothing, hold PC=RESET_PC, then go to RUN.
REQ-019 imem_addr SHALL equal PC combinationally; capture latency SHALL be one cycle (word at PC appears on id_inst the next edge).
REQ-020 RUN priority per edge SHALL be: fault > br_taken > stall > normal advance.
REQ-021 Normal advance: PC <= PC+4; id_inst <= imem_data; id_pc <= PC; id_pc4 <= PC+4; id_valid <= ~flush.
REQ-022 br_taken: PC <= br_target; id_valid <= 0 (wrong-path word dropped); br_taken overrides a simultaneous stall.
REQ-023 stall without br_taken: PC, id_inst, id_pc, id_pc4 and id_valid SHALL all hold; a simultaneous flush SHALL clear id_valid only.
REQ-024 Fault condition: PC[1:0] != 0 or PC+3 >= IMEM_BYTES while in RUN.
REQ-025 On fault: fetch_fault <= 1, id_valid <= 0, state <= HALT, no capture.
REQ-026 HALT SHALL hold PC and all id_* outputs, keep id_valid=0 and fetch_fault=1, ignore stall/flush/br_taken, and be exited only by reset.
REQ-027 PC+4 arithmetic SHALL be 32-bit modulo; wrap-around is caught by REQ-024.
REQ-028 perf_fetch_cnt SHALL increment on every edge that sets id_valid to 1 and wrap at 2^32.

Reset
REQ-029 rst_n low SHALL set PC=RESET_PC, state=BOOT, id_valid=0, id_inst=0, id_pc=0, id_pc4=0, fetch_fault=0 and perf_fetch_cnt=0 immediately, without waiting for clk.
REQ-030 Reset asserted mid-operation, including in HALT, SHALL abandon any capture and restart from BOOT.

Configuration
REQ-031 Macro PC_FETCH_PERF_CNT_EN defined: perf_fetch_cnt counts per REQ-028.
REQ-032 Macro PC_FETCH_PERF_CNT_EN undefined: counter logic absent; perf_fetch_cnt tied to 32'h0; all other behaviour identical.

Verification
REQ-033 Reset release, memory words 0x11111111/0x22222222 at 0/4 -> BOOT one cycle; id_inst=0x11111111, id_pc=0 and id_valid=1, then 0x22222222 with id_pc=4.
REQ-034 stall high for 3 cycles at PC=8 -> imem_addr stays 8 and id_* outputs hold; on release, id_pc=8 and PC=12.
REQ-035 br_taken with stall at PC=12, br_target=0x20 -> next edge id_valid=0 and PC=0x20; following edge id_pc=0x20.
REQ-036 flush at PC=16 -> id_valid=0 and PC=20; perf_fetch_cnt unchanged (macro defined).
REQ-037 br_target=0x42 (misaligned), and separately sequential fetch reaching PC=72 with IMEM_BYTES=72 -> fetch_fault=1, HALT, id_valid=0; rst_n low clears to PC=0.
REQ-038 Build with and without PC_FETCH_PERF_CNT_EN -> after 5 valid fetches the counter reads 5 versus 0; all other outputs match cycle-for-cycle.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, one-cycle capture of the instruction word, and fault detection.
// Optional macro PC_FETCH_PERF_CNT_EN enables the delivered-instruction counter on perf_fetch_cnt.
module pc_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 72
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        fetch_fault,
   output logic [31:0] perf_fetch_cnt,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] idpc_q, idpc_d;
   logic [31:0] idpc4_q, idpc4_d;
   logic        fault_q, fault_d;
   logic        advance;
   logic [31:0] pc_plus4;
   logic [32:0] last_byte;
   logic        fault_now;

   assign pc_plus4  = pc_q + 32'd4;
   // 33-bit sum so a PC near the top of the address space cannot wrap below the limit.
   assign last_byte = {1'b0, pc_q} + 33'd3;
   assign fault_now = (pc_q[1:0] != 2'b00) || (last_byte >= 33'(IMEM_BYTES));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      inst_d  = inst_q;
      idpc_d  = idpc_q;
      idpc4_d = idpc4_q;
      fault_d = fault_q;
      advance = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (fault_now) begin
               fault_d = 1'b1;
               valid_d = 1'b0;
               state_d = HALT;
            end else if (br_taken) begin
               pc_d    = br_target;
               valid_d = 1'b0;
            end else if (stall) begin
               if (flush) valid_d = 1'b0;
            end else begin
               advance = 1'b1;
               pc_d    = pc_plus4;
               inst_d  = imem_data;
               idpc_d  = pc_q;
               idpc4_d = pc_plus4;
               valid_d = ~flush;
            end
         end
         HALT: begin
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         inst_q  <= 32'h0;
         idpc_q  <= 32'h0;
         idpc4_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         idpc_q  <= idpc_d;
         idpc4_q <= idpc4_d;
         fault_q <= fault_d;
      end
   end

`ifdef PC_FETCH_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   assign cnt_d = (advance && !flush) ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 32'h0;
      else        cnt_q <= cnt_d;
   end

   assign perf_fetch_cnt = cnt_q;
`else
   assign perf_fetch_cnt = 32'h0;
`endif

   assign imem_addr   = pc_q;
   assign id_valid    = valid_q;
   assign id_inst     = inst_q;
   assign id_pc       = idpc_q;
   assign id_pc4      = idpc4_q;
   assign fetch_fault = fault_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then randomized episodes against a behavioural fetch model.
module tb_pc_fetch;

   localparam int MEM_BYTES = 72;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        fetch_fault;
   logic [31:0] perf_fetch_cnt;
   logic [1:0]  dbg_state;

   logic [7:0]  mem [0:MEM_BYTES-1];

   int n_vec;
   int n_err;

   // model of the fetch stage
   longint      m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_idpc;
   logic [31:0] m_idpc4;
   logic        m_fault;
   logic [31:0] m_cnt;
   int          m_phase;   // 0 = first cycle after reset, 1 = fetching, 2 = stopped

   pc_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .stall          (stall),
      .flush          (flush),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4),
      .fetch_fault    (fetch_fault),
      .perf_fetch_cnt (perf_fetch_cnt),
      .dbg_state      (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input longint a);
      if (a < 0 || a + 3 >= MEM_BYTES) return 32'hDEAD_BEEF;
      return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
   endfunction

   assign imem_data = mem_word(longint'(imem_addr));

   task automatic set_word(input int a, input logic [31:0] w);
      mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef PC_FETCH_PERF_CNT_EN
      return m_cnt;
`else
      return 32'h0;
`endif
   endfunction

   task automatic check_all();
      chk("imem_addr", imem_addr, m_pc[31:0]);
      chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
      chk("id_inst", id_inst, m_inst);
      chk("id_pc", id_pc, m_idpc);
      chk("id_pc4", id_pc4, m_idpc4);
      chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
      chk("perf_cnt", perf_fetch_cnt, exp_cnt());
   endtask

   task automatic model_reset();
      m_pc = 0; m_valid = 0; m_inst = 0; m_idpc = 0; m_idpc4 = 0;
      m_fault = 0; m_cnt = 0; m_phase = 0;
   endtask

   task automatic model_step(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
      if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if ((m_pc % 4) != 0 || m_pc + 3 >= MEM_BYTES) begin
            m_fault = 1; m_valid = 0; m_phase = 2;
         end else if (br) begin
            m_pc = longint'(tgt); m_valid = 0;
         end else if (st) begin
            if (fl) m_valid = 0;
         end else begin
            m_inst  = mem_word(m_pc);
            m_idpc  = m_pc[31:0];
            m_idpc4 = 32'(m_pc + 4);
            m_valid = !fl;
            if (!fl) m_cnt = m_cnt + 1;
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
         end
      end
   endtask

   // called at a falling edge; applies inputs for the next rising edge
   task automatic cycle(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
      stall = st; flush = fl; br_taken = br; br_target = tgt;
      #1;
      chk("addr_pre", imem_addr, m_pc[31:0]);
      @(posedge clk);
      model_step(st, fl, br, tgt);
      @(negedge clk);
      check_all();
   endtask

   // reset asserted between edges and checked before the next rising edge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      stall = 0; flush = 0; br_taken = 0; br_target = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] cnt_before;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; stall = 0; flush = 0; br_taken = 0; br_target = 0;
      for (int i = 0; i < MEM_BYTES; i += 4) set_word(i, 32'hA000_0000 + 32'(i));
      set_word(0, 32'h1111_1111);
      set_word(4, 32'h2222_2222);
      model_reset();
      @(negedge clk);
      do_reset();

      // startup: one idle cycle, then words at 0 and 4
      cycle(0, 0, 0, 0);
      chk("boot_valid", {31'h0, id_valid}, 32'h0);
      cycle(0, 0, 0, 0);
      chk("first_inst", id_inst, 32'h1111_1111);
      chk("first_pc", id_pc, 32'h0);
      chk("first_valid", {31'h0, id_valid}, 32'h1);
      cycle(0, 0, 0, 0);
      chk("second_inst", id_inst, 32'h2222_2222);
      chk("second_pc", id_pc, 32'h4);

      // three stalled cycles at PC=8
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 0);
         chk("stall_addr", imem_addr, 32'h8);
         chk("stall_hold_pc", id_pc, 32'h4);
      end
      cycle(0, 0, 0, 0);
      chk("release_pc", id_pc, 32'h8);
      chk("release_addr", imem_addr, 32'hC);

      // branch wins over stall
      cycle(1, 0, 1, 32'h20);
      chk("br_valid", {31'h0, id_valid}, 32'h0);
      chk("br_addr", imem_addr, 32'h20);
      cycle(0, 0, 0, 0);
      chk("br_id_pc", id_pc, 32'h20);

      // flush at PC=16
      cycle(0, 0, 1, 32'h10);
      cnt_before = perf_fetch_cnt;
      cycle(0, 1, 0, 0);
      chk("flush_valid", {31'h0, id_valid}, 32'h0);
      chk("flush_addr", imem_addr, 32'h14);
      chk("flush_cnt", perf_fetch_cnt, cnt_before);
      cycle(0, 0, 0, 0);

      // misaligned branch target halts the stage
      cycle(0, 0, 1, 32'h42);
      cycle(0, 0, 0, 0);
      chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
      chk("mis_valid", {31'h0, id_valid}, 32'h0);
      cycle(1, 1, 1, 32'h0);
      cycle(0, 0, 1, 32'h8);
      chk("halt_addr", imem_addr, 32'h42);
      do_reset();
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

      // five deliveries, then run off the end of memory
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
`ifdef PC_FETCH_PERF_CNT_EN
      chk("cnt_five", perf_fetch_cnt, 32'd5);
`else
      chk("cnt_five", perf_fetch_cnt, 32'd0);
`endif
      for (int i = 0; i < 13; i++) cycle(0, 0, 0, 0);
      chk("end_addr", imem_addr, 32'd72);
      cycle(0, 0, 0, 0);
      chk("range_fault", {31'h0, fetch_fault}, 32'h1);
      chk("range_valid", {31'h0, id_valid}, 32'h0);
      chk("range_last_pc", id_pc, 32'd68);

      // randomized episodes
      for (int ep = 0; ep < 6; ep++) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
         do_reset();
         for (int c = 0; c < 40; c++) begin
            logic        st, fl, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 127))
                                              : 32'($urandom_range(0, 17) * 4);
            cycle(st, fl, br, tgt);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
